// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if
//   Request/response handshake bundle between a requester and the ALU
//   sequencer.
//   req_valid/req_ready  : request handshake; req_op/req_a/req_b carry the
//                          opcode and operands.
//   rsp_valid/rsp_ready  : response handshake; rsp_result plus the
//                          zero/carry/sign/err flags carry the outcome.
//   modport master : requester side (drives req_*, rsp_ready)
//   modport slave  : sequencer side (drives req_ready, rsp_*)
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_sign;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_sign, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_sign, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Accepts one ALU request at a time, drives operands to an external
//   multi-cycle ALU for an opcode-dependent number of cycles, captures the
//   ALU result and flags, and presents them on a response handshake.
//   Divide/modulo by zero and undefined opcodes are answered directly with
//   an error response without ever enabling the ALU.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     flush        : synchronous abort of any in-flight operation
//     bus          : request/response handshake (slave side)
//     alu_tmp1/alu_tmp2/alu_op/alu_enable : operands, opcode, enable to ALU
//     alu_result/alu_zero/alu_carry/alu_sign : ALU outputs
//     busy         : high whenever the sequencer is not idle
module alu_sequencer #(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_sequencer_if.slave bus,
  output logic [15:0] alu_tmp1,
  output logic [15:0] alu_tmp2,
  output logic [2:0]  alu_op,
  output logic        alu_enable,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_sign,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Counter is loaded with W-1 so that EXEC lasts exactly W cycles.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_WAIT - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_WAIT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [15:0] tmp1_reg, tmp2_reg;
  logic [2:0]  op_reg;
  logic [15:0] rsp_result_reg;
  logic        rsp_zero_reg, rsp_carry_reg, rsp_sign_reg, rsp_err_reg;

  logic        accept;
  logic        illegal;
  logic [3:0]  load_cnt;

  assign accept = (state_reg == IDLE) && bus.req_valid && !flush;

  // Requests that can never produce a valid ALU result bypass EXEC.
  assign illegal = (bus.req_op > 3'd4) ||
                   (((bus.req_op == 3'd3) || (bus.req_op == 3'd4)) && (bus.req_b == 16'h0000));

  always_comb begin
    load_cnt = 4'd0;
    case (bus.req_op)
      3'd2:    load_cnt = MUL_LOAD;
      3'd3,
      3'd4:    load_cnt = DIV_LOAD;
      default: load_cnt = 4'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; flush wins over everything else.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (bus.req_valid) state_next = illegal ? RESP : EXEC;
        EXEC: if (cnt_reg == 4'd0) state_next = RESP;
        RESP: if (bus.rsp_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.req_ready = (state_reg == IDLE);
    bus.rsp_valid = (state_reg == RESP);
    alu_enable    = (state_reg == EXEC);
    busy          = (state_reg != IDLE);
  end

  // Datapath: operand latch, wait counter, response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= 4'd0;
      tmp1_reg       <= 16'h0000;
      tmp2_reg       <= 16'h0000;
      op_reg         <= 3'b000;
      rsp_result_reg <= 16'h0000;
      rsp_zero_reg   <= 1'b0;
      rsp_carry_reg  <= 1'b0;
      rsp_sign_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else if (accept) begin
      tmp1_reg <= bus.req_a;
      tmp2_reg <= bus.req_b;
      op_reg   <= bus.req_op;
      cnt_reg  <= illegal ? 4'd0 : load_cnt;
      if (illegal) begin
        rsp_result_reg <= 16'h0000;
        rsp_zero_reg   <= 1'b1;
        rsp_carry_reg  <= 1'b0;
        rsp_sign_reg   <= 1'b0;
        rsp_err_reg    <= 1'b1;
      end
    end else if (flush) begin
      // Abandoned operations leave the previous response untouched.
      cnt_reg <= 4'd0;
    end else if (state_reg == EXEC) begin
      if (cnt_reg == 4'd0) begin
        rsp_result_reg <= alu_result;
        rsp_zero_reg   <= alu_zero;
        rsp_carry_reg  <= alu_carry;
        rsp_sign_reg   <= alu_sign;
        rsp_err_reg    <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  assign alu_tmp1       = tmp1_reg;
  assign alu_tmp2       = tmp2_reg;
  assign alu_op         = op_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_zero   = rsp_zero_reg;
  assign bus.rsp_carry  = rsp_carry_reg;
  assign bus.rsp_sign   = rsp_sign_reg;
  assign bus.rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Self-checking bench for alu_sequencer (MUL_WAIT=3, DIV_WAIT=4).
//   A behavioural multi-cycle ALU only presents its true result on the
//   final enabled cycle of an operation and random values otherwise, so a
//   sequencer capturing on the wrong cycle is visible in the response.
module tb_alu_sequencer;
  localparam int MUL_W = 3;
  localparam int DIV_W = 4;

  typedef struct {
    logic [15:0] r;
    logic        z, c, s, e;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] alu_tmp1, alu_tmp2;
  logic [2:0]  alu_op;
  logic        alu_enable;
  logic [15:0] alu_result = 16'h0000;
  logic        alu_zero = 1'b0, alu_carry = 1'b0, alu_sign = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer #(.MUL_WAIT(MUL_W), .DIV_WAIT(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus.slave),
    .alu_tmp1   (alu_tmp1),
    .alu_tmp2   (alu_tmp2),
    .alu_op     (alu_op),
    .alu_enable (alu_enable),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_sign   (alu_sign),
    .busy       (busy)
  );

  // Reference: expected response and edges-after-accept to rsp_valid.
  // Carry is defined by this ALU as signed overflow for add/sub.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t x;
    x.r = 16'h0000; x.c = 1'b0; x.e = 1'b0; x.lat = 0;
    case (op)
      3'd0: begin x.r = a + b; x.c = (a[15] == b[15]) && (x.r[15] != a[15]); x.lat = 1; end
      3'd1: begin x.r = a - b; x.c = (a[15] != b[15]) && (x.r[15] != a[15]); x.lat = 1; end
      3'd2: begin x.r = a * b; x.lat = MUL_W; end
      3'd3: if (b != 16'h0000) begin x.r = a / b; x.lat = DIV_W; end else x.e = 1'b1;
      3'd4: if (b != 16'h0000) begin x.r = a % b; x.lat = DIV_W; end else x.e = 1'b1;
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == 16'h0000);
    x.s = x.r[15];
    return x;
  endfunction

  // Behavioural multi-cycle ALU
  exp_t alu_m;
  int   en_run = 0;
  always_comb alu_m = ref_model(alu_op, alu_tmp1, alu_tmp2);

  always @(negedge clk) begin
    en_run <= alu_enable ? en_run + 1 : 0;
    if (alu_enable && (en_run + 1 == alu_m.lat)) begin
      alu_result <= alu_m.r;
      alu_zero   <= alu_m.z;
      alu_carry  <= alu_m.c;
      alu_sign   <= alu_m.s;
    end else begin
      alu_result <= 16'($urandom);
      alu_zero   <= 1'($urandom);
      alu_carry  <= 1'($urandom);
      alu_sign   <= 1'($urandom);
    end
  end

  // Drives one request from IDLE and completes the response handshake.
  // got.lat = edges after the accepting edge until rsp_valid (-1 on timeout).
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, output exp_t got, output int en_cnt, output bit stable);
    int lat;
    lat = 0; en_cnt = 0; stable = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_op = 3'($urandom); bus.req_a = 16'($urandom); bus.req_b = 16'($urandom);
    while (!bus.rsp_valid && lat < 40) begin
      if (alu_enable) en_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    got.lat = bus.rsp_valid ? lat : -1;
    got.r = bus.rsp_result; got.z = bus.rsp_zero; got.c = bus.rsp_carry;
    got.s = bus.rsp_sign;   got.e = bus.rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== got.r || bus.rsp_err !== got.e ||
          bus.rsp_zero !== got.z || bus.rsp_carry !== got.c || bus.rsp_sign !== got.s)
        stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, busy, alu_enable} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000", {bus.req_ready, bus.rsp_valid, busy, alu_enable});
    end
    checks++;
    if ({alu_tmp1, alu_tmp2, alu_op} !== 35'd0) begin
      failures++;
      $display("FAIL reset_alu_regs got=%h/%h/%h exp=0", alu_tmp1, alu_tmp2, alu_op);
    end
    checks++;
    if ({bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_sign, bus.rsp_err} !== 20'd0) begin
      failures++;
      $display("FAIL reset_rsp got=%h flags=%b exp=0", bus.rsp_result,
               {bus.rsp_zero, bus.rsp_carry, bus.rsp_sign, bus.rsp_err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release got=%b exp=100", {bus.req_ready, bus.rsp_valid, busy});
    end
  endtask

  task automatic test_add_overflow;
    exp_t g; int en; bit st;
    run_op(3'd0, 16'h7FFF, 16'h0001, 0, g, en, st);
    $display("txn add a=7fff b=0001 res=%h lat=%0d", g.r, g.lat);
    checks++; if (g.lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", g.lat); end
    checks++; if (en !== 1) begin failures++; $display("FAIL add_enable got=%0d exp=1", en); end
    checks++; if (g.r !== 16'h8000) begin failures++; $display("FAIL add_result got=%h exp=8000", g.r); end
    checks++;
    if ({g.z, g.c, g.s, g.e} !== 4'b0110) begin
      failures++; $display("FAIL add_flags got=%b exp=0110", {g.z, g.c, g.s, g.e});
    end
  endtask

  task automatic test_mul;
    exp_t g; int en; bit st;
    run_op(3'd2, 16'h0003, 16'hFFFE, 0, g, en, st);
    $display("txn mul a=0003 b=fffe res=%h lat=%0d", g.r, g.lat);
    checks++; if (g.lat !== 3) begin failures++; $display("FAIL mul_latency got=%0d exp=3", g.lat); end
    checks++; if (en !== 3) begin failures++; $display("FAIL mul_enable got=%0d exp=3", en); end
    checks++; if (g.r !== 16'hFFFA) begin failures++; $display("FAIL mul_result got=%h exp=fffa", g.r); end
    checks++; if (g.s !== 1'b1) begin failures++; $display("FAIL mul_sign got=%b exp=1", g.s); end
  endtask

  task automatic test_div_zero;
    exp_t g; int en; bit st;
    logic [2:0] ops [2];
    ops[0] = 3'd3; ops[1] = 3'd6;
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], 16'h0010, 16'h0000, 1, g, en, st);
      $display("txn op=%0d a=0010 b=0000 res=%h err=%b lat=%0d", ops[i], g.r, g.e, g.lat);
      checks++; if (g.lat !== 0) begin failures++; $display("FAIL err_latency op=%0d got=%0d exp=0", ops[i], g.lat); end
      checks++; if (en !== 0) begin failures++; $display("FAIL err_enable op=%0d got=%0d exp=0", ops[i], en); end
      checks++;
      if (g.r !== 16'h0000 || {g.z, g.c, g.s, g.e} !== 4'b1001) begin
        failures++;
        $display("FAIL err_rsp op=%0d got=%h/%b exp=0000/1001", ops[i], g.r, {g.z, g.c, g.s, g.e});
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = 16'd5; bus.req_b = 16'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'hFFFE || bus.rsp_sign !== 1'b1) begin
      failures++;
      $display("FAIL sub_rsp got=%b/%h/%b exp=1/fffe/1", bus.rsp_valid, bus.rsp_result, bus.rsp_sign);
    end
    $display("txn sub a=5 b=7 res=%h", bus.rsp_result);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'hFFFE || bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL sub_hold cyc=%0d got=%b/%h/%b exp=1/fffe/0", i, bus.rsp_valid, bus.rsp_result, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL handshake_idle got=%b/%b exp=0/1", busy, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL second_accept got=%b exp=1", busy); end
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'hFFFE) begin
      failures++; $display("FAIL second_rsp got=%b/%h exp=1/fffe", bus.rsp_valid, bus.rsp_result);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_flush;
    exp_t g; int en; bit st; int seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_a = 16'd100; bus.req_b = 16'd7;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || alu_enable !== 1'b0) begin
      failures++;
      $display("FAIL flush_exec got=%b/%b/%b exp=1/0/0", bus.req_ready, bus.rsp_valid, alu_enable);
    end
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.rsp_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_rsp got=%0d exp=0", seen); end
    run_op(3'd4, 16'd17, 16'd5, 0, g, en, st);
    $display("txn mod a=17 b=5 res=%h lat=%0d", g.r, g.lat);
    checks++;
    if (g.r !== 16'h0002 || g.lat !== 4 || g.e !== 1'b0) begin
      failures++; $display("FAIL mod_after_flush got=%h/%0d/%b exp=0002/4/0", g.r, g.lat, g.e);
    end
    // flush while a response is pending
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 16'd1; bus.req_b = 16'd2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_resp got=%b/%b exp=0/0", bus.rsp_valid, busy);
    end
    // flush blocks an accept in IDLE
    bus.req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_blocks_accept got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset;
    int seen;
    logic [2:0] ops [2];
    ops[0] = 3'd2; ops[1] = 3'd7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = ops[i]; bus.req_a = 16'h1234; bus.req_b = 16'h0005;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, busy, alu_enable} !== 4'b1000 || alu_tmp1 !== 16'h0000 ||
          bus.rsp_err !== 1'b0 || bus.rsp_result !== 16'h0000) begin
        failures++;
        $display("FAIL async_reset op=%0d ctrl=%b tmp1=%h err=%b res=%h exp=1000/0000/0/0000", ops[i],
                 {bus.req_ready, bus.rsp_valid, busy, alu_enable}, alu_tmp1, bus.rsp_err, bus.rsp_result);
      end
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (bus.rsp_valid || busy) seen++; end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL async_reset_no_rsp op=%0d got=%0d exp=0", ops[i], seen); end
    end
  endtask

  task automatic test_random;
    exp_t g, x; int en; bit st;
    logic [2:0] op; logic [15:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      x  = ref_model(op, a, b);
      run_op(op, a, b, $urandom_range(0, 3), g, en, st);
      $display("txn rnd%0d op=%0d a=%h b=%h res=%h exp=%h lat=%0d", i, op, a, b, g.r, x.r, g.lat);
      checks++;
      if (g.lat !== x.lat || en !== x.lat) begin
        failures++; $display("FAIL rnd_timing i=%0d lat=%0d en=%0d exp=%0d", i, g.lat, en, x.lat);
      end
      checks++;
      if (g.r !== x.r || {g.z, g.c, g.s, g.e} !== {x.z, x.c, x.s, x.e}) begin
        failures++;
        $display("FAIL rnd_rsp i=%0d got=%h/%b exp=%h/%b", i, g.r, {g.z, g.c, g.s, g.e}, x.r, {x.z, x.c, x.s, x.e});
      end
      checks++;
      if (st !== 1'b1) begin failures++; $display("FAIL rnd_stable i=%0d got=0 exp=1", i); end
      checks++;
      if (alu_tmp1 !== a || alu_tmp2 !== b || alu_op !== op) begin
        failures++;
        $display("FAIL rnd_operands i=%0d got=%h/%h/%0d exp=%h/%h/%0d", i, alu_tmp1, alu_tmp2, alu_op, a, b, op);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 16'h0000; bus.req_b = 16'h0000;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add_overflow();
    test_mul();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_WAIT, default 2, EXEC cycles for op 3'b010 (legal 1..15).
REQ-002 Parameter DIV_WAIT, default 4, EXEC cycles for op 3'b011 and 3'b100 (legal 1..15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  synchronous abort of in-flight operation.
REQ-006 req_valid  in  1 / req_ready  out  1  request handshake.
REQ-007 req_op  in  3 / req_a  in  16 / req_b  in  16  opcode (0 add, 1 sub, 2 mul, 3 div, 4 mod) and operands.
REQ-008 rsp_valid  out  1 / rsp_ready  in  1  response handshake.
REQ-009 rsp_result  out  16 / rsp_zero, rsp_carry, rsp_sign, rsp_err  out  1 each  captured result and flags.
REQ-010 alu_tmp1, alu_tmp2  out  16 / alu_op  out  3 / alu_enable  out  1  drive to ALU.
REQ-011 alu_result  in  16 / alu_zero, alu_carry, alu_sign  in  1 each  ALU outputs.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 States SHALL be IDLE, EXEC, RESP; req_ready SHALL equal (state==IDLE).
REQ-014 Accept SHALL occur on an edge with state IDLE, req_valid=1, flush=0; req_a/req_b/req_op latch into alu_tmp1/alu_tmp2/alu_op on that edge.
REQ-015 Wait count W SHALL be 1 for op 0/1, MUL_WAIT for op 2, DIV_WAIT for op 3/4; a 4-bit counter loads W-1 at accept.
REQ-016 Legal accept with nonzero divisor (or op 0..2) SHALL go IDLE->EXEC.
REQ-017 In EXEC alu_enable SHALL be 1; counter decrements each edge; alu_enable is 0 in every other state.
REQ-018 On the EXEC edge with counter==0, alu_result/alu_zero/alu_carry/alu_sign SHALL be captured into rsp_*, rsp_err<=0, state->RESP.
REQ-019 rsp_valid SHALL assert after exactly W edges following the accepting edge; alu_enable is high for exactly W cycles.
REQ-020 Op 3/4 with req_b==0, or op 5..7, SHALL go IDLE->RESP directly: rsp_result=0x0000, rsp_zero=1, rsp_carry=0, rsp_sign=0, rsp_err=1, rsp_valid after 1 edge, alu_enable never asserted.
REQ-021 rsp_valid SHALL equal (state==RESP); rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-022 RESP->IDLE SHALL occur on the edge with rsp_ready=1; no request is accepted on that edge (min 1 IDLE cycle between operations).
REQ-023 req_valid SHALL be ignored outside IDLE; req_* need not be held after accept.
REQ-024 flush=1 SHALL force state->IDLE on the next edge from any state, discarding any in-flight or pending response (no rsp_valid), and SHALL block accept on that edge.
REQ-025 alu_tmp1/alu_tmp2/alu_op SHALL hold last latched values in IDLE and RESP; rsp_* hold last values after handshake.
REQ-026 Arithmetic SHALL be performed only by the ALU; the sequencer never modifies alu_result or flags except per REQ-020.

Reset
REQ-027 rst_n low SHALL immediately set state IDLE, counter 0, alu_tmp1/alu_tmp2=0x0000, alu_op=3'b000, rsp_result=0x0000, all rsp flags 0; thus rsp_valid=0, alu_enable=0, busy=0, req_ready=1.
REQ-028 Reset asserted mid-EXEC or mid-RESP SHALL abandon the operation with no response after rst_n deasserts.

Verification
REQ-029 ADD a=0x7FFF b=0x0001 -> rsp_valid 1 edge after accept, rsp_result=0x8000, carry=1, sign=1, zero=0, err=0.
REQ-030 MUL_WAIT=3, MUL a=0x0003 b=0xFFFE -> alu_enable high exactly 3 cycles, rsp_valid on 3rd edge, rsp_result=0xFFFA, sign=1.
REQ-031 DIV a=0x0010 b=0x0000 -> rsp_valid after 1 edge, rsp_result=0x0000, zero=1, err=1, alu_enable never high; op 3'b110 same response.
REQ-032 SUB a=5 b=7 with rsp_ready low 5 cycles and req_valid held high -> rsp_result=0xFFFE, sign=1, stable 5 cycles, req_ready=0, no second accept until 1 cycle after rsp handshake.
REQ-033 DIV_WAIT=4, DIV started, flush pulsed in 2nd EXEC cycle -> no rsp_valid, req_ready=1 next cycle; following MOD a=17 b=5 -> rsp_result=0x0002.
REQ-034 rst_n pulsed low asynchronously (between edges) in EXEC -> outputs reach reset values immediately; no rsp_valid after release.
